rand_stim_gen: RTL and testbench

Hardware constrained-random stimulus source that sits directly upstream of `design_rand` and drives its `a` and `b` operands.
- A 16-bit Galois LFSR supplies raw bits.
- `a` is produced by rejection sampling against a range constraint; `b` by a fixed weighted distribution (values 1–3 weight 2 each, 4 weight 5, 9 weight 3).
- Each accepted pair is offered on a valid/ready handshake, and a programmable number of pairs is emitted per `start` request.

---
 rtl/rand_stim_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_rand_stim_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_stim_gen.sv
// Constrained-random operand source for design_rand.
// A 16-bit Galois LFSR feeds two generation states: 'a' is rejection-sampled
// against A_LIMIT, 'b' follows a fixed weighted table. Each accepted pair is
// offered on a valid/ready handshake; COUNT pairs are emitted per start.
module rand_stim_gen #(
  parameter int unsigned WIDTH   = 4,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned A_LIMIT = 3,
  parameter int unsigned MAX_TRY = 8,
  parameter int unsigned COUNT   = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      sample_cnt_o
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]      TAPS     = 16'hB400;
  localparam int unsigned      TRY_W    = (MAX_TRY < 2) ? 1 : $clog2(MAX_TRY + 1);
  // Fallback fires on the rejection that would bring the counter to MAX_TRY.
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY - 1);
  localparam logic [15:0]      COUNT_16 = 16'(COUNT);
  localparam logic [WIDTH-1:0] B_FALLBK = WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN_A,
    S_GEN_B,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_step;
  logic [WIDTH-1:0] w_cand;
  logic [3:0]       w_r;

  logic [TRY_W-1:0] r_try;
  logic [15:0]      r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_a_ok;
  logic             w_b_ok;
  logic [WIDTH-1:0] w_b_val;

  logic             w_lfsr_en;
  logic             w_a_load;
  logic [WIDTH-1:0] w_a_next;
  logic             w_b_load;
  logic [WIDTH-1:0] w_b_next;
  logic             w_try_clr;
  logic             w_try_inc;
  logic             w_cnt_clr;
  logic             w_cnt_inc;

  // One Galois step; the candidate is taken from the post-step value.
  always_comb begin
    w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
    w_cand      = w_lfsr_step[WIDTH-1:0];
    w_r         = w_lfsr_step[3:0];
    w_a_ok      = (32'(w_cand) < A_LIMIT);
  end

  // Weighted 'b' table: 0-5 -> 1+r/2, 6-10 -> 4, 11-13 -> 9, 14-15 rejected.
  always_comb begin
    w_b_ok  = 1'b1;
    w_b_val = '0;
    if (w_r <= 4'd5) begin
      w_b_val = WIDTH'(1) + WIDTH'(w_r[3:1]);
    end else if (w_r <= 4'd10) begin
      w_b_val = WIDTH'(4);
    end else if (w_r <= 4'd13) begin
      w_b_val = WIDTH'(9);
    end else begin
      w_b_ok = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_en   = 1'b0;
    w_a_load    = 1'b0;
    w_a_next    = '0;
    w_b_load    = 1'b0;
    w_b_next    = '0;
    w_try_clr   = 1'b0;
    w_try_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_GEN_A;
          w_cnt_clr   = 1'b1;
          w_try_clr   = 1'b1;
        end
      end
      S_GEN_A: begin
        w_lfsr_en = 1'b1;
        if (w_a_ok) begin
          w_a_load    = 1'b1;
          w_a_next    = w_cand;
          w_try_clr   = 1'b1;
          w_state_nxt = S_GEN_B;
        end else if (r_try == TRY_LAST) begin
          w_a_load    = 1'b1;
          w_a_next    = '0;
          w_try_clr   = 1'b1;
          w_state_nxt = S_GEN_B;
        end else begin
          w_try_inc = 1'b1;
        end
      end
      S_GEN_B: begin
        w_lfsr_en = 1'b1;
        if (w_b_ok) begin
          w_b_load    = 1'b1;
          w_b_next    = w_b_val;
          w_try_clr   = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (r_try == TRY_LAST) begin
          w_b_load    = 1'b1;
          w_b_next    = B_FALLBK;
          w_try_clr   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_try_inc = 1'b1;
        end
      end
      S_HOLD: begin
        if (ready_i) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = ((r_cnt + 16'd1) == COUNT_16) ? S_DONE : S_GEN_A;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // LFSR advances only while generating; it persists across bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED_EFF;
    end else if (w_lfsr_en) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // Per-field rejection counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_try <= '0;
    end else if (w_try_clr) begin
      r_try <= '0;
    end else if (w_try_inc) begin
      r_try <= r_try + TRY_W'(1);
    end
  end

  // Handshake counter for the current burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Operand registers change only on accept/fallback, so they hold through HOLD and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_a_load) begin
        r_a <= w_a_next;
      end
      if (w_b_load) begin
        r_b <= w_b_next;
      end
    end
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == S_HOLD);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign a_o          = r_a;
  assign b_o          = r_b;
  assign valid_o      = r_valid;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign sample_cnt_o = r_cnt;

endmodule

// File: tb/tb_rand_stim_gen.sv
// Bench for rand_stim_gen: a spec-level LFSR model predicts every pair and
// its generation cycle count; a scoreboard queue compares on each transfer.
`timescale 1ns/1ps
module tb_rand_stim_gen;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    int unsigned cyc;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start1 = 1'b0;
  logic        ready1 = 1'b0;
  logic        start2 = 1'b0;
  logic        ready2 = 1'b1;
  logic [3:0]  a1, b1, a2, b2;
  logic        valid1, busy1, done1, valid2, busy2, done2;
  logic [15:0] cnt1, cnt2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [15:0] m1_s = 16'hACE1;
  logic [15:0] m2_s = 16'hACE1;
  int unsigned gen1 = 0, gen2 = 0, nx1 = 0, nx2 = 0, ndone1 = 0;
  int unsigned hist_exp[16] = '{default: 0};
  int unsigned hist_act[16] = '{default: 0};
  logic [3:0]  last_a1 = '0;
  logic [3:0]  last_b1 = '0;

  always #5 clk = ~clk;

  rand_stim_gen #(
    .WIDTH(4), .SEED(16'hACE1), .A_LIMIT(3), .MAX_TRY(8), .COUNT(100)
  ) u_dut (
    .clk(clk), .rst(rst), .start_i(start1), .ready_i(ready1),
    .a_o(a1), .b_o(b1), .valid_o(valid1), .busy_o(busy1),
    .done_o(done1), .sample_cnt_o(cnt1)
  );

  rand_stim_gen #(
    .WIDTH(4), .SEED(16'hACE1), .A_LIMIT(0), .MAX_TRY(8), .COUNT(3)
  ) u_dut_fb (
    .clk(clk), .rst(rst), .start_i(start2), .ready_i(ready2),
    .a_o(a2), .b_o(b2), .valid_o(valid2), .busy_o(busy2),
    .done_o(done2), .sample_cnt_o(cnt2)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic b_in_set(input logic [3:0] b);
    return (b == 4'd1) || (b == 4'd2) || (b == 4'd3) || (b == 4'd4) || (b == 4'd9);
  endfunction

  // Reference generation of one pair from the documented rules.
  task automatic model_pair(input int unsigned alim, input logic [15:0] s_in,
                            output logic [15:0] s_out, output exp_t e);
    logic [15:0] s;
    logic [3:0]  c;
    int unsigned tries;
    bit          fin;
    s = s_in; e.a = '0; e.b = '0; e.cyc = 0;
    tries = 0; fin = 0;
    while (!fin) begin
      s = lfsr_step(s); e.cyc = e.cyc + 1; c = s[3:0];
      if (32'(c) < alim) begin e.a = c; fin = 1; end
      else begin
        tries++;
        if (tries == 8) begin e.a = '0; fin = 1; end
      end
    end
    tries = 0; fin = 0;
    while (!fin) begin
      s = lfsr_step(s); e.cyc = e.cyc + 1; c = s[3:0];
      if (c <= 4'd5)       begin e.b = 4'd1 + {1'b0, c[3:1]}; fin = 1; end
      else if (c <= 4'd10) begin e.b = 4'd4; fin = 1; end
      else if (c <= 4'd13) begin e.b = 4'd9; fin = 1; end
      else begin
        tries++;
        if (tries == 8) begin e.b = 4'd4; fin = 1; end
      end
    end
    s_out = s;
  endtask

  task automatic push1(input int unsigned n);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      model_pair(3, m1_s, m1_s, e);
      q1.push_back(e);
      hist_exp[e.b]++;
      last_a1 = e.a;
      last_b1 = e.b;
    end
  endtask

  task automatic push2(input int unsigned n);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      model_pair(0, m2_s, m2_s, e);
      q2.push_back(e);
    end
  endtask

  task automatic wait_valid1(input string tag, output int unsigned edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      start1 = 1'b0;
      edges++;
    end while (!valid1 && edges < 60);
    chk_eq(tag, 32'(valid1), 1);
  endtask

  // Scoreboard for the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      gen1 = 0;
    end else begin
      if (busy1 && !valid1 && !done1) gen1++;
      if (done1) ndone1++;
      if (valid1 && ready1) begin
        if (q1.size() == 0) begin
          chk_eq("sb1_underflow", 32'(q1.size()), 1);
        end else begin
          e = q1.pop_front();
          chk_eq("sb1_a", 32'(a1), 32'(e.a));
          chk_eq("sb1_b", 32'(b1), 32'(e.b));
          chk_eq("sb1_gen_cycles", gen1, e.cyc);
          chk_eq("a_below_limit", 32'(a1 < 4'd3), 1);
          chk_eq("b_in_set", 32'(b_in_set(b1)), 1);
          hist_act[b1]++;
        end
        gen1 = 0;
        nx1++;
      end
    end
  end

  // Scoreboard for the fallback instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      gen2 = 0;
    end else begin
      if (busy2 && !valid2 && !done2) gen2++;
      if (valid2 && ready2) begin
        if (q2.size() == 0) begin
          chk_eq("sb2_underflow", 32'(q2.size()), 1);
        end else begin
          e = q2.pop_front();
          chk_eq("fb_a", 32'(a2), 32'(e.a));
          chk_eq("fb_b", 32'(b2), 32'(e.b));
          chk_eq("fb_gen_cycles", gen2, e.cyc);
        end
        gen2 = 0;
        nx2++;
      end
    end
  end

  initial begin
    int unsigned edges;
    int unsigned vals[5] = '{1, 2, 3, 4, 9};

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_a", 32'(a1), 0);
    chk_eq("rst_b", 32'(b1), 0);
    chk_eq("rst_valid", 32'(valid1), 0);
    chk_eq("rst_busy", 32'(busy1), 0);
    chk_eq("rst_done", 32'(done1), 0);
    chk_eq("rst_cnt", 32'(cnt1), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fallback instance: A_LIMIT=0 forces MAX_TRY GEN_A cycles per pair
    start2 = 1'b1;
    push2(3);
    edges = 0;
    do begin
      @(posedge clk); #1;
      start2 = 1'b0;
      edges++;
    end while (!done2 && edges < 300);
    chk_eq("fb_done", 32'(done2), 1);
    chk_eq("fb_xfers", nx2, 3);
    chk_eq("fb_cnt", 32'(cnt2), 3);
    chk_eq("fb_sb_left", 32'(q2.size()), 0);

    // Burst 1: first pair, second pair, backpressure, then random ready
    ready1 = 1'b1;
    start1 = 1'b1;
    push1(100);
    wait_valid1("first_valid", edges);
    chk_eq("first_latency", edges, 3);
    chk_eq("first_a", 32'(a1), 0);
    chk_eq("first_b", 32'(b1), 4);
    wait_valid1("second_valid", edges);
    chk_eq("second_latency", edges, 9);
    chk_eq("second_a", 32'(a1), 2);
    chk_eq("second_b", 32'(b1), 1);

    ready1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk_eq("bp_valid", 32'(valid1), 1);
      chk_eq("bp_a", 32'(a1), 2);
      chk_eq("bp_b", 32'(b1), 1);
      chk_eq("bp_cnt", 32'(cnt1), 1);
    end
    ready1 = 1'b1;
    @(posedge clk); #1;
    ready1 = 1'b0;
    chk_eq("release_cnt", 32'(cnt1), 2);
    chk_eq("release_valid", 32'(valid1), 0);
    @(posedge clk); #1;
    chk_eq("release_one_xfer", 32'(cnt1), 2);

    edges = 0;
    while (!done1 && edges < 10000) begin
      ready1 = 1'($urandom_range(0, 1));
      start1 = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      edges++;
    end
    start1 = 1'b0;
    ready1 = 1'b0;
    chk_eq("burst_done", 32'(done1), 1);
    chk_eq("burst_xfers", nx1, 100);
    chk_eq("burst_cnt", 32'(cnt1), 100);
    chk_eq("burst_sb_left", 32'(q1.size()), 0);
    @(posedge clk); #1;
    chk_eq("done_one_cycle", 32'(done1), 0);
    chk_eq("busy_after_done", 32'(busy1), 0);
    chk_eq("valid_idle", 32'(valid1), 0);
    chk_eq("cnt_hold_idle", 32'(cnt1), 100);
    chk_eq("done_pulses", ndone1, 1);
    chk_eq("idle_a_hold", 32'(a1), 32'(last_a1));
    chk_eq("idle_b_hold", 32'(b1), 32'(last_b1));
    for (int i = 0; i < 5; i++) begin
      chk_eq("b_histogram", hist_act[vals[i]], hist_exp[vals[i]]);
    end

    // Burst 2: LFSR continues; reset mid-cycle while a pair is held
    ready1 = 1'b1;
    start1 = 1'b1;
    push1(100);
    wait_valid1("b2_valid_first", edges);
    wait_valid1("b2_valid_second", edges);
    ready1 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_eq("async_rst_a", 32'(a1), 0);
    chk_eq("async_rst_b", 32'(b1), 0);
    chk_eq("async_rst_valid", 32'(valid1), 0);
    chk_eq("async_rst_busy", 32'(busy1), 0);
    chk_eq("async_rst_done", 32'(done1), 0);
    chk_eq("async_rst_cnt", 32'(cnt1), 0);
    q1.delete();
    m1_s = 16'hACE1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_eq("post_rst_busy", 32'(busy1), 0);
      chk_eq("post_rst_valid", 32'(valid1), 0);
    end

    // Burst 3: LFSR back at the seed, so the pair sequence restarts
    ready1 = 1'b1;
    start1 = 1'b1;
    push1(100);
    wait_valid1("b3_valid_first", edges);
    chk_eq("b3_latency", edges, 3);
    chk_eq("b3_a", 32'(a1), 0);
    chk_eq("b3_b", 32'(b1), 4);
    wait_valid1("b3_valid_second", edges);
    chk_eq("b3_a2", 32'(a1), 2);
    chk_eq("b3_b2", 32'(b1), 1);
    ready1 = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
